// File: rtl/ir_debounce.sv
// IR presence sensor debouncer: two-flop synchronizer, four-state confirm/release FSM,
// registered level output, detect/release pulses and a saturating detection counter.
module ir_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir_pin,
  input  logic                 cnt_clear,
  output logic                 obj_present,
  output logic                 det_pulse,
  output logic                 rel_pulse,
  output logic [CNT_WIDTH-1:0] det_count
);

  localparam int TW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    ARMING    = 2'd1,
    DETECTED  = 2'd2,
    RELEASING = 2'd3
  } state_t;

  logic [1:0]    sync;
  logic          sample_active;
  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic          det_evt, rel_evt;

  // Idle level of the sensor is high, so the synchronizer resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], ir_pin};
  end

  assign sample_active = ~sync[1];

  always_comb begin
    state_d = state;
    timer_d = timer;
    det_evt = 1'b0;
    rel_evt = 1'b0;
    unique case (state)
      CLEAR: begin
        timer_d = '0;
        if (sample_active) begin
          state_d = ARMING;
          timer_d = TW'(1);
        end
      end
      ARMING: begin
        if (!sample_active) begin
          state_d = CLEAR;
          timer_d = '0;
        end else if (timer == TMAX) begin
          state_d = DETECTED;
          timer_d = '0;
          det_evt = 1'b1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      DETECTED: begin
        timer_d = '0;
        if (!sample_active) begin
          state_d = RELEASING;
          timer_d = TW'(1);
        end
      end
      RELEASING: begin
        if (sample_active) begin
          // Inactive run too short: fall back silently.
          state_d = DETECTED;
          timer_d = '0;
        end else if (timer == TMAX) begin
          state_d = CLEAR;
          timer_d = '0;
          rel_evt = 1'b1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CLEAR;
      timer       <= '0;
      obj_present <= 1'b0;
      det_pulse   <= 1'b0;
      rel_pulse   <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      obj_present <= (state_d == DETECTED) || (state_d == RELEASING);
      det_pulse   <= det_evt;
      rel_pulse   <= rel_evt;
    end
  end

  // Count lands on the same edge as det_pulse; a coincident clear keeps the new detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   det_count <= '0;
    else if (cnt_clear)        det_count <= det_evt ? CNT_WIDTH'(1) : '0;
    else if (det_evt && (det_count != {CNT_WIDTH{1'b1}}))
                               det_count <= det_count + CNT_WIDTH'(1);
  end

endmodule
